conv_tile_scheduler: RTL

- Parametrised successor to the convolution dataflow controller.
- Walks the full tiled loop nest: output-channel tile m, then output-spatial tile n, then input-channel tile k, then kernel row kh, then kernel column kw.
- Emits one fetch/compute command per innermost step on a valid/ready stream to the buffer-fetch and PE-array sequencer.
- Adds runtime depthwise mode, config validation, backpressure, abort, and per-command accumulate clear/last flags.

---
 rtl/conv_tile_scheduler.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/conv_tile_scheduler.sv
// Tiled convolution loop-nest walker: m -> n -> k -> kh -> kw, one command per step.
// Optional perf counters (perf_cmd_cnt, perf_stall_cnt) when CONV_SCHED_PERF_EN is defined.
module conv_tile_scheduler #(
  parameter int TILE_M     = 16,
  parameter int TILE_N     = 16,
  parameter int TILE_K     = 16,
  parameter int DIM_WIDTH  = 16,
  parameter int ADDR_WIDTH = 18
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [DIM_WIDTH-1:0]        cfg_in_h,
  input  logic [DIM_WIDTH-1:0]        cfg_in_w,
  input  logic [DIM_WIDTH-1:0]        cfg_in_c,
  input  logic [DIM_WIDTH-1:0]        cfg_out_c,
  input  logic [3:0]                  cfg_k_h,
  input  logic [3:0]                  cfg_k_w,
  input  logic [3:0]                  cfg_stride_h,
  input  logic [3:0]                  cfg_stride_w,
  input  logic [3:0]                  cfg_pad_t,
  input  logic [3:0]                  cfg_pad_b,
  input  logic [3:0]                  cfg_pad_l,
  input  logic [3:0]                  cfg_pad_r,
  input  logic                        cfg_depthwise,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [DIM_WIDTH-1:0]        out_h,
  output logic [DIM_WIDTH-1:0]        out_w,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic [ADDR_WIDTH-1:0]       cmd_w_addr,
  output logic [ADDR_WIDTH-1:0]       cmd_a_addr,
  output logic signed [DIM_WIDTH:0]   cmd_in_row,
  output logic signed [DIM_WIDTH:0]   cmd_in_col,
  output logic                        cmd_pad,
  output logic                        cmd_clear,
  output logic                        cmd_last,
  output logic [DIM_WIDTH-1:0]        cmd_m_base,
  output logic [DIM_WIDTH-1:0]        cmd_n_base,
`ifdef CONV_SCHED_PERF_EN
  output logic [31:0]                 perf_cmd_cnt,
  output logic [31:0]                 perf_stall_cnt,
`endif
  output logic [2:0]                  dbg_state
);

  localparam int W2 = 2 * DIM_WIDTH;
  localparam int SW = W2 + 1;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_DONE, S_ERROR} state_t;
  state_t state, next_state;

  logic [DIM_WIDTH-1:0] in_h, in_w, in_c, out_c;
  logic [3:0]           k_h, k_w, st_h, st_w, pd_t, pd_b, pd_l, pd_r;
  logic                 dw;
  logic [DIM_WIDTH-1:0] m_base, kb, k_base;
  logic [W2-1:0]        n_base;
  logic [3:0]           kh, kw;

  logic accept, issuing, fire, cfg_ok;
  logic kw_last, kh_last, k_last, n_last, m_last, all_last;
  logic [W2-1:0] span_h, span_w, oh_calc, ow_calc, npix, ow_div, orow, ocol, w_full, a_full;
  logic signed [SW-1:0] row_full, col_full;
  logic row_pad, col_pad;

  // Stream contract: a command transfers on a cycle with cmd_valid && cmd_ready; while
  // cmd_valid && !cmd_ready every cmd_* field holds, and cmd_valid only drops without a
  // transfer on abort or reset.
  assign accept  = (state == S_IDLE) && start;
  assign issuing = (state == S_ISSUE);
  assign fire    = issuing && cmd_ready;
  assign busy    = (state != S_IDLE);
  assign dbg_state = state;

  always_comb begin
    span_h  = W2'(in_h) + W2'(pd_t) + W2'(pd_b);
    span_w  = W2'(in_w) + W2'(pd_l) + W2'(pd_r);
    cfg_ok  = (k_h != 4'd0) && (k_w != 4'd0) && (st_h != 4'd0) && (st_w != 4'd0) &&
              (W2'(k_h) <= span_h) && (W2'(k_w) <= span_w) &&
              (in_c != '0) && (out_c != '0) && !(dw && (in_c != out_c));
    oh_calc = (span_h - W2'(k_h)) / W2'((st_h == 4'd0) ? 4'd1 : st_h) + W2'(1);
    ow_calc = (span_w - W2'(k_w)) / W2'((st_w == 4'd0) ? 4'd1 : st_w) + W2'(1);
    npix    = W2'(out_h) * W2'(out_w);

    kw_last  = (kw == k_w - 4'd1);
    kh_last  = (kh == k_h - 4'd1);
    k_last   = dw || (W2'(kb) + W2'(TILE_K) >= W2'(in_c));
    n_last   = (n_base + W2'(TILE_N) >= npix);
    m_last   = (W2'(m_base) + W2'(TILE_M) >= W2'(out_c));
    all_last = kw_last && kh_last && k_last && n_last && m_last;

    // Depthwise: each output channel reads only its own input channel plane.
    k_base  = dw ? m_base : kb;
    ow_div  = (out_w == '0) ? W2'(1) : W2'(out_w);
    orow    = n_base / ow_div;
    ocol    = n_base % ow_div;
    w_full  = (W2'(m_base) * (dw ? W2'(1) : W2'(in_c)) + (dw ? '0 : W2'(k_base)))
              * W2'(k_h) * W2'(k_w) + W2'(kh) * W2'(k_w) + W2'(kw);
    a_full  = W2'(k_base) * W2'(in_h) * W2'(in_w);
    row_full = $signed(SW'(orow * W2'(st_h))) + $signed(SW'(kh)) - $signed(SW'(pd_t));
    col_full = $signed(SW'(ocol * W2'(st_w))) + $signed(SW'(kw)) - $signed(SW'(pd_l));
    row_pad  = row_full[SW-1] || (row_full >= $signed(SW'(in_h)));
    col_pad  = col_full[SW-1] || (col_full >= $signed(SW'(in_w)));
  end

  always_comb begin
    cmd_valid  = issuing;
    cmd_w_addr = '0;
    cmd_a_addr = '0;
    cmd_in_row = '0;
    cmd_in_col = '0;
    cmd_pad    = 1'b0;
    cmd_clear  = 1'b0;
    cmd_last   = 1'b0;
    cmd_m_base = '0;
    cmd_n_base = '0;
    if (issuing) begin
      cmd_w_addr = ADDR_WIDTH'(w_full);
      cmd_a_addr = ADDR_WIDTH'(a_full);
      cmd_in_row = (DIM_WIDTH+1)'(row_full);
      cmd_in_col = (DIM_WIDTH+1)'(col_full);
      cmd_pad    = row_pad || col_pad;
      cmd_clear  = (kb == '0 || dw) && (kh == 4'd0) && (kw == 4'd0);
      cmd_last   = k_last && kh_last && kw_last;
      cmd_m_base = m_base;
      cmd_n_base = DIM_WIDTH'(n_base);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_CHECK;
      S_CHECK: next_state = abort ? S_IDLE : (cfg_ok ? S_ISSUE : S_ERROR);
      // A final transfer coinciding with abort still completes normally.
      S_ISSUE: if (fire && all_last) next_state = S_DONE;
               else if (abort)       next_state = S_IDLE;
      S_DONE:  next_state = S_IDLE;
      S_ERROR: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= next_state;
      done  <= (next_state == S_DONE) || (next_state == S_ERROR) ||
               (abort && (state != S_IDLE) && (next_state == S_IDLE));
      err   <= (next_state == S_ERROR);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_h <= '0; in_w <= '0; in_c <= '0; out_c <= '0;
      k_h <= '0; k_w <= '0; st_h <= '0; st_w <= '0;
      pd_t <= '0; pd_b <= '0; pd_l <= '0; pd_r <= '0; dw <= 1'b0;
      out_h <= '0; out_w <= '0;
      m_base <= '0; n_base <= '0; kb <= '0; kh <= '0; kw <= '0;
    end else begin
      if (accept) begin
        in_h <= cfg_in_h; in_w <= cfg_in_w; in_c <= cfg_in_c; out_c <= cfg_out_c;
        k_h <= cfg_k_h; k_w <= cfg_k_w; st_h <= cfg_stride_h; st_w <= cfg_stride_w;
        pd_t <= cfg_pad_t; pd_b <= cfg_pad_b; pd_l <= cfg_pad_l; pd_r <= cfg_pad_r;
        dw <= cfg_depthwise;
        m_base <= '0; n_base <= '0; kb <= '0; kh <= '0; kw <= '0;
      end
      if (state == S_CHECK) begin
        out_h <= cfg_ok ? DIM_WIDTH'(oh_calc) : '0;
        out_w <= cfg_ok ? DIM_WIDTH'(ow_calc) : '0;
      end
      if (fire) begin
        if (!kw_last) kw <= kw + 4'd1;
        else begin
          kw <= '0;
          if (!kh_last) kh <= kh + 4'd1;
          else begin
            kh <= '0;
            if (!k_last) kb <= kb + DIM_WIDTH'(TILE_K);
            else begin
              kb <= '0;
              if (!n_last) n_base <= n_base + W2'(TILE_N);
              else begin
                n_base <= '0;
                if (!m_last) m_base <= m_base + DIM_WIDTH'(TILE_M);
              end
            end
          end
        end
      end
    end
  end

`ifdef CONV_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cmd_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else if (accept) begin
      perf_cmd_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (fire && (perf_cmd_cnt != '1)) perf_cmd_cnt <= perf_cmd_cnt + 32'd1;
      if (issuing && !cmd_ready && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  // Build without performance counters: no extra state.
`endif

endmodule
